decode_queue: RTL and testbench
===============================

DECODE_QUEUE -- requirements
Module: decode_queue

Interface
REQ-001 Parameter ROB_WIDTH, default 4, width of ROB tags.
REQ-002 Parameter IQ_LOG, default 3, log2 of instruction-queue depth (depth D = 2^IQ_LOG).
REQ-003 Clocking SHALL be: one clock, clk_in; reset is asynchronous and active-low, rst_n_in.
REQ-004 Ports, in order (name, direction, width, meaning):
- clk_in  in  1  clock.
- rst_n_in  in  1  async active-low reset.
- rdy_in  in  1  global enable.
- clear  in  1  flush (mispredict).
- if_valid  in  1  fetch offers an instruction.
- if_pc  in  32  PC of the offered instruction.
- if_inst  in  32  offered instruction word.
- if_ready  out  1  queue can accept.
- rob_ready  in  1  ROB has a free entry.
- rs_ready  in  1  RS has a free entry.
- lsb_ready  in  1  LSB has a free entry.
- rob_tag  in  ROB_WIDTH  tag of the next free ROB entry.
- to_rob, to_rs, to_lsb  out  1 each  one-cycle dispatch strobes.
- d_op  out  6  op code; d_rd, d_rs1, d_rs2  out  5 each; d_imm  out  32; d_pc  out  32; d_tag  out  ROB_WIDTH; d_illegal  out  1.

Function
REQ-005 Queue: circular FIFO, D entries of {pc, inst}; head/tail pointers IQ_LOG bits wrapping modulo D; count IQ_LOG+1 bits.
REQ-006 if_ready = (count != D), derived from registered count only; push on an edge where if_valid && if_ready && rdy_in && !clear.
REQ-007 Push while full is impossible; push and pop on the same edge SHALL leave count unchanged.
REQ-008 Pop/dispatch on an edge where count != 0, rob_ready, rdy_in, !clear, and the target unit is ready (rs_ready for RS-class, lsb_ready for load/store; rob_ready only for illegal).
REQ-009 Latency: an instruction pushed at edge N is dispatched at edge N+1 at the earliest; dispatch outputs are registered.
REQ-010 On dispatch: to_rob=1 for exactly one cycle; to_rs=1 for ALU/branch/jump/LUI/AUIPC; to_lsb=1 for loads/stores; d_tag=rob_tag; d_pc=entry pc; d_rd/rs1/rs2 = inst[11:7]/[19:15]/[24:20].
REQ-011 Without a dispatch at an edge, to_rob/to_rs/to_lsb SHALL be 0 after that edge; other d_* hold.
REQ-012 Op encoding (decimal): ADD0 SUB1 AND2 OR3 XOR4 SLL5 SRL6 SRA7 SLT8 SLTU9 ADDI10 ANDI11 ORI12 XORI13 SLLI14 SRLI15 SRAI16 SLTI17 SLTIU18 LB19 LBU20 LH21 LHU22 LW23 SB24 SH25 SW26 BEQ27 BGE28 BGEU29 BLT30 BLTU31 BNE32 JAL33 JALR34 AUIPC35 LUI36.
REQ-013 Immediates: I-type sign-extended inst[31:20] (SLTIU and load offsets also sign-extended); shift-imm zero-extended inst[24:20]; S-type sign-extended {inst[31:25],inst[11:7]}; B-type sign-extended {inst[31],inst[7],inst[30:25],inst[11:8],0}; J-type sign-extended {inst[31],inst[19:12],inst[20],inst[30:21],0}; U-type {inst[31:12],12'b0}; R-type 0.
REQ-014 Any unrecognised opcode/funct3/funct7 combination: d_illegal=1, d_op=0, to_rob only, to_rs=to_lsb=0; otherwise d_illegal=0.
REQ-015 Head blocked by its own target unit SHALL stall in order; no bypass of younger entries.
REQ-016 clear at an edge: head=tail=count=0, strobes 0, same-cycle push and dispatch discarded; clear dominates all.
REQ-017 rdy_in=0 at an edge: all state and outputs hold (clear still acts only when rdy_in=1).

Reset
REQ-018 rst_n_in low asynchronously forces head=tail=count=0, to_rob=to_rs=to_lsb=0, d_illegal=0, all other d_* = 0; if_ready=1 after release.

Verification
REQ-019 Push 0xFFF10093 (ADDI x1,x2,-1), all ready -> next edge to_rob=to_rs=1, d_op=10, d_rd=1, d_rs1=2, d_imm=0xFFFFFFFF, d_tag=rob_tag.
REQ-020 Push 0x00512423 (SW x5,8(x2)) with lsb_ready=0 for 3 cycles -> no strobes; after lsb_ready=1, one to_lsb+to_rob pulse, d_op=26, d_rs2=5, d_imm=8.
REQ-021 Push 0x010000EF (JAL x1,16) -> d_op=33, d_imm=16, to_rs=1.
REQ-022 rob_ready=0, push 8 instructions -> if_ready=0 after 8th edge; raise rob_ready -> 8 dispatches in push order, pointers wrap, if_ready returns to 1.
REQ-023 Queue holding 5 entries, assert clear with if_valid=1 -> count=0, no strobes, offered word dropped.
REQ-024 Push 0x00000000 -> to_rob=1, d_illegal=1, to_rs=to_lsb=0; rst_n_in pulsed mid-stream -> all strobes 0 immediately.

Source files
------------

// File: rtl/decode_queue.sv
// decode_queue: fetch-side instruction FIFO with in-order RV32I decode and registered dispatch
// to the ROB, reservation station or load/store buffer.
module decode_queue #(
  parameter int ROB_WIDTH = 4,
  parameter int IQ_LOG    = 3
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 rdy_in,
  input  logic                 clear,
  input  logic                 if_valid,
  input  logic [31:0]          if_pc,
  input  logic [31:0]          if_inst,
  output logic                 if_ready,
  input  logic                 rob_ready,
  input  logic                 rs_ready,
  input  logic                 lsb_ready,
  input  logic [ROB_WIDTH-1:0] rob_tag,
  output logic                 to_rob,
  output logic                 to_rs,
  output logic                 to_lsb,
  output logic [5:0]           d_op,
  output logic [4:0]           d_rd,
  output logic [4:0]           d_rs1,
  output logic [4:0]           d_rs2,
  output logic [31:0]          d_imm,
  output logic [31:0]          d_pc,
  output logic [ROB_WIDTH-1:0] d_tag,
  output logic                 d_illegal
);
  typedef enum logic [5:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_SLTU,
    OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLLI, OP_SRLI, OP_SRAI, OP_SLTI, OP_SLTIU,
    OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW,
    OP_BEQ, OP_BGE, OP_BGEU, OP_BLT, OP_BLTU, OP_BNE,
    OP_JAL, OP_JALR, OP_AUIPC, OP_LUI
  } op_t;
  localparam logic [IQ_LOG:0] DEPTH = (IQ_LOG+1)'(1) << IQ_LOG;
  logic [31:0]       pc_mem   [1<<IQ_LOG];
  logic [31:0]       inst_mem [1<<IQ_LOG];
  logic [IQ_LOG-1:0] head, tail;
  logic [IQ_LOG:0]   count;
  logic [31:0]       inst, imm, imm_i, imm_s, imm_b, imm_j, imm_u, imm_sh;
  logic [6:0]        opc, f7;
  logic [2:0]        f3;
  op_t               op;
  logic              ill, mem, push, pop;
  assign if_ready = count != DEPTH;
  assign push     = rdy_in && !clear && if_valid && if_ready;
  assign inst     = inst_mem[head];
  assign opc      = inst[6:0];
  assign f3       = inst[14:12];
  assign f7       = inst[31:25];
  assign imm_i    = {{20{inst[31]}}, inst[31:20]};
  assign imm_s    = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b    = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_j    = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign imm_u    = {inst[31:12], 12'b0};
  assign imm_sh   = {27'b0, inst[24:20]};
  always_comb begin
    op  = OP_ADD;
    imm = '0;
    ill = 1'b0;
    mem = 1'b0;
    case (opc)
      7'b0110011:
        case ({f7, f3})
          10'b0000000_000: op = OP_ADD;
          10'b0100000_000: op = OP_SUB;
          10'b0000000_111: op = OP_AND;
          10'b0000000_110: op = OP_OR;
          10'b0000000_100: op = OP_XOR;
          10'b0000000_001: op = OP_SLL;
          10'b0000000_101: op = OP_SRL;
          10'b0100000_101: op = OP_SRA;
          10'b0000000_010: op = OP_SLT;
          10'b0000000_011: op = OP_SLTU;
          default:         ill = 1'b1;
        endcase
      7'b0010011: begin
        imm = imm_i;
        case (f3)
          3'b000: op = OP_ADDI;
          3'b111: op = OP_ANDI;
          3'b110: op = OP_ORI;
          3'b100: op = OP_XORI;
          3'b010: op = OP_SLTI;
          3'b011: op = OP_SLTIU;
          3'b001: begin
            op  = OP_SLLI;
            imm = imm_sh;
            ill = f7 != 7'b0;
          end
          default: begin
            op  = f7[5] ? OP_SRAI : OP_SRLI;
            imm = imm_sh;
            ill = {f7[6], f7[4:0]} != 6'b0;
          end
        endcase
      end
      7'b0000011: begin
        imm = imm_i;
        mem = 1'b1;
        case (f3)
          3'b000:  op = OP_LB;
          3'b100:  op = OP_LBU;
          3'b001:  op = OP_LH;
          3'b101:  op = OP_LHU;
          3'b010:  op = OP_LW;
          default: ill = 1'b1;
        endcase
      end
      7'b0100011: begin
        imm = imm_s;
        mem = 1'b1;
        case (f3)
          3'b000:  op = OP_SB;
          3'b001:  op = OP_SH;
          3'b010:  op = OP_SW;
          default: ill = 1'b1;
        endcase
      end
      7'b1100011: begin
        imm = imm_b;
        case (f3)
          3'b000:  op = OP_BEQ;
          3'b101:  op = OP_BGE;
          3'b111:  op = OP_BGEU;
          3'b100:  op = OP_BLT;
          3'b110:  op = OP_BLTU;
          3'b001:  op = OP_BNE;
          default: ill = 1'b1;
        endcase
      end
      7'b1101111: begin
        op  = OP_JAL;
        imm = imm_j;
      end
      7'b1100111: begin
        op  = OP_JALR;
        imm = imm_i;
        ill = f3 != 3'b000;
      end
      7'b0010111: begin
        op  = OP_AUIPC;
        imm = imm_u;
      end
      7'b0110111: begin
        op  = OP_LUI;
        imm = imm_u;
      end
      default: ill = 1'b1;
    endcase
    // illegal words carry no decode payload and never reach a functional unit
    if (ill) begin
      op  = OP_ADD;
      imm = '0;
      mem = 1'b0;
    end
  end
  assign pop = rdy_in && !clear && count != '0 && rob_ready && (ill || (mem ? lsb_ready : rs_ready));
  always_ff @(posedge clk_in) begin
    if (push) begin
      pc_mem[tail]   <= if_pc;
      inst_mem[tail] <= if_inst;
    end
  end
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      to_rob    <= 1'b0;
      to_rs     <= 1'b0;
      to_lsb    <= 1'b0;
      d_op      <= '0;
      d_rd      <= '0;
      d_rs1     <= '0;
      d_rs2     <= '0;
      d_imm     <= '0;
      d_pc      <= '0;
      d_tag     <= '0;
      d_illegal <= 1'b0;
    end else if (rdy_in) begin
      if (clear) begin
        head   <= '0;
        tail   <= '0;
        count  <= '0;
        to_rob <= 1'b0;
        to_rs  <= 1'b0;
        to_lsb <= 1'b0;
      end else begin
        if (push) tail <= tail + 1'b1;
        if (pop) head <= head + 1'b1;
        count  <= count + {{IQ_LOG{1'b0}}, push} - {{IQ_LOG{1'b0}}, pop};
        to_rob <= pop;
        to_rs  <= pop && !ill && !mem;
        to_lsb <= pop && mem;
        if (pop) begin
          d_op      <= op;
          d_rd      <= inst[11:7];
          d_rs1     <= inst[19:15];
          d_rs2     <= inst[24:20];
          d_imm     <= imm;
          d_pc      <= pc_mem[head];
          d_tag     <= rob_tag;
          d_illegal <= ill;
        end
      end
    end
  end
endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: random and directed stimulus against a table-driven decode/queue model.
module tb_decode_queue;
  localparam int D = 8;
  logic clk_in = 0, rst_n_in = 0, rdy_in = 0, clear = 0, if_valid = 0;
  logic [31:0] if_pc = 0, if_inst = 0;
  logic if_ready, rob_ready = 0, rs_ready = 0, lsb_ready = 0;
  logic [3:0] rob_tag = 0;
  logic to_rob, to_rs, to_lsb, d_illegal;
  logic [5:0] d_op;
  logic [4:0] d_rd, d_rs1, d_rs2;
  logic [31:0] d_imm, d_pc;
  logic [3:0] d_tag;
  int errors = 0, checks = 0;

  decode_queue #(.ROB_WIDTH(4), .IQ_LOG(3)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .clear(clear),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .if_ready(if_ready),
    .rob_ready(rob_ready), .rs_ready(rs_ready), .lsb_ready(lsb_ready), .rob_tag(rob_tag),
    .to_rob(to_rob), .to_rs(to_rs), .to_lsb(to_lsb), .d_op(d_op), .d_rd(d_rd),
    .d_rs1(d_rs1), .d_rs2(d_rs2), .d_imm(d_imm), .d_pc(d_pc), .d_tag(d_tag),
    .d_illegal(d_illegal));

  always #5 clk_in = ~clk_in;

  // match pattern and immediate format per op number (0 R, 1 I, 2 shift-imm, 3 S, 4 B, 5 J, 6 U)
  logic [31:0] match_t [37] = '{
    32'h33, 32'h40000033, 32'h7033, 32'h6033, 32'h4033, 32'h1033, 32'h5033, 32'h40005033, 32'h2033, 32'h3033,
    32'h13, 32'h7013, 32'h6013, 32'h4013, 32'h1013, 32'h5013, 32'h40005013, 32'h2013, 32'h3013,
    32'h03, 32'h4003, 32'h1003, 32'h5003, 32'h2003, 32'h23, 32'h1023, 32'h2023,
    32'h63, 32'h5063, 32'h7063, 32'h4063, 32'h6063, 32'h1063,
    32'h6F, 32'h67, 32'h17, 32'h37};
  int fmt_t [37] = '{0,0,0,0,0,0,0,0,0,0, 1,1,1,1,2,2,2,1,1, 1,1,1,1,1, 3,3,3, 4,4,4,4,4,4, 5,1,6,6};

  typedef struct { int op; logic [31:0] imm; bit ill; bit lsb; } dec_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;

  function automatic logic [31:0] fmask(int f);
    return (f == 0 || f == 2) ? 32'hFE00707F : (f >= 5) ? 32'h7F : 32'h707F;
  endfunction

  function automatic dec_t decode(logic [31:0] w);
    dec_t r;
    int f = -1;
    r = '{0, 0, 1'b1, 1'b0};
    for (int i = 0; i < 37; i++)
      if ((w & fmask(fmt_t[i])) == match_t[i]) begin
        r.op = i;
        r.ill = 0;
        f = fmt_t[i];
      end
    case (f)
      1: r.imm = (w[31] ? 32'hFFFFF800 : 0) | ((w >> 20) & 32'h7FF);
      2: r.imm = (w >> 20) & 32'h1F;
      3: r.imm = (w[31] ? 32'hFFFFF800 : 0) | (((w >> 25) & 63) << 5) | ((w >> 7) & 31);
      4: r.imm = (w[31] ? 32'hFFFFF000 : 0) | (32'(w[7]) << 11) | (((w >> 25) & 63) << 5) | (((w >> 8) & 15) << 1);
      5: r.imm = (w[31] ? 32'hFFF00000 : 0) | (w & 32'h000FF000) | (((w >> 20) & 1) << 11) | (((w >> 21) & 32'h3FF) << 1);
      6: r.imm = w & 32'hFFFFF000;
      default: r.imm = 0;
    endcase
    r.lsb = !r.ill && r.op >= 19 && r.op <= 26;
    return r;
  endfunction

  function automatic logic [31:0] rand_inst();
    int i;
    if ($urandom_range(7) == 0) return $urandom;
    i = $urandom_range(36);
    return ($urandom & ~fmask(fmt_t[i])) | match_t[i];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  ent_t q[$];
  bit e_rob, e_rs, e_lsb, e_ill;
  logic [31:0] e_op, e_imm, e_pc, e_rd, e_rs1, e_rs2, e_tag, hi;
  dec_t dh;
  bit pop;
  int n;

  always @(posedge clk_in) begin
    if (!rst_n_in) begin
      q.delete();
      {e_rob, e_rs, e_lsb, e_ill} = 0;
      {e_op, e_imm, e_pc, e_rd, e_rs1, e_rs2, e_tag} = 0;
    end else if (rdy_in) begin
      if (clear) begin
        q.delete();
        {e_rob, e_rs, e_lsb} = 0;
      end else begin
        n = q.size();
        pop = 0;
        dh = '{0, 0, 1'b0, 1'b0};
        if (n > 0) begin
          hi = q[0].inst;
          dh = decode(hi);
          pop = rob_ready && (dh.ill || (dh.lsb ? lsb_ready : rs_ready));
        end
        e_rob = pop;
        e_rs = pop && !dh.ill && !dh.lsb;
        e_lsb = pop && dh.lsb;
        if (pop) begin
          e_op = dh.op;
          e_imm = dh.imm;
          e_ill = dh.ill;
          e_pc = q[0].pc;
          e_rd = (hi >> 7) & 31;
          e_rs1 = (hi >> 15) & 31;
          e_rs2 = (hi >> 20) & 31;
          e_tag = 32'(rob_tag);
          void'(q.pop_front());
        end
        if (if_valid && n < D) q.push_back('{if_pc, if_inst});
      end
    end
    #1;
    chk("to_rob", 32'(to_rob), 32'(e_rob));
    chk("to_rs", 32'(to_rs), 32'(e_rs));
    chk("to_lsb", 32'(to_lsb), 32'(e_lsb));
    chk("if_ready", 32'(if_ready), 32'(q.size() != D));
    chk("d_op", 32'(d_op), e_op);
    chk("d_rd", 32'(d_rd), e_rd);
    chk("d_rs1", 32'(d_rs1), e_rs1);
    chk("d_rs2", 32'(d_rs2), e_rs2);
    chk("d_imm", d_imm, e_imm);
    chk("d_pc", d_pc, e_pc);
    chk("d_tag", 32'(d_tag), e_tag);
    chk("d_illegal", 32'(d_illegal), 32'(e_ill));
  end

  task automatic cyc();
    @(posedge clk_in);
    #2;
  endtask

  initial begin
    cyc();
    cyc();
    chk("rst to_rob", 32'(to_rob), 0);
    chk("rst d_imm", d_imm, 0);
    chk("rst if_ready", 32'(if_ready), 1);
    rst_n_in = 1;
    rdy_in = 1;
    rob_ready = 1; rs_ready = 1; lsb_ready = 1; rob_tag = 5;
    // ADDI x1,x2,-1
    if_valid = 1; if_pc = 32'h100; if_inst = 32'hFFF10093;
    cyc();
    if_valid = 0;
    cyc();
    chk("addi to_rob", 32'(to_rob), 1);
    chk("addi to_rs", 32'(to_rs), 1);
    chk("addi op", 32'(d_op), 10);
    chk("addi rd", 32'(d_rd), 1);
    chk("addi rs1", 32'(d_rs1), 2);
    chk("addi imm", d_imm, 32'hFFFFFFFF);
    chk("addi tag", 32'(d_tag), 5);
    // SW x5,8(x2) held back by the LSB
    if_valid = 1; if_pc = 32'h104; if_inst = 32'h00512423; lsb_ready = 0;
    cyc();
    if_valid = 0;
    repeat (3) begin
      cyc();
      chk("sw stall lsb", 32'(to_lsb), 0);
      chk("sw stall rob", 32'(to_rob), 0);
    end
    lsb_ready = 1;
    cyc();
    chk("sw to_lsb", 32'(to_lsb), 1);
    chk("sw to_rob", 32'(to_rob), 1);
    chk("sw op", 32'(d_op), 26);
    chk("sw rs2", 32'(d_rs2), 5);
    chk("sw imm", d_imm, 8);
    cyc();
    chk("sw one pulse", 32'(to_rob), 0);
    // JAL x1,16
    if_valid = 1; if_pc = 32'h108; if_inst = 32'h010000EF;
    cyc();
    if_valid = 0;
    cyc();
    chk("jal op", 32'(d_op), 33);
    chk("jal imm", d_imm, 16);
    chk("jal to_rs", 32'(to_rs), 1);
    // fill to full, then drain in order across the pointer wrap
    rob_ready = 0;
    for (int i = 0; i < 8; i++) begin
      if_valid = 1; if_pc = 32'h200 + 4 * i; if_inst = 32'h13 | ((i + 1) << 7);
      cyc();
    end
    if_valid = 0;
    chk("full if_ready", 32'(if_ready), 0);
    rob_ready = 1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("drain to_rob", 32'(to_rob), 1);
      chk("drain pc", d_pc, 32'h200 + 4 * i);
      chk("drain rd", 32'(d_rd), i + 1);
    end
    chk("drained if_ready", 32'(if_ready), 1);
    // flush five queued entries together with an offered word
    rob_ready = 0;
    for (int i = 0; i < 5; i++) begin
      if_valid = 1; if_pc = 32'h300 + 4 * i; if_inst = 32'h00100093;
      cyc();
    end
    clear = 1; if_inst = 32'h00200113;
    cyc();
    chk("clear to_rob", 32'(to_rob), 0);
    chk("clear if_ready", 32'(if_ready), 1);
    clear = 0; if_valid = 0; rob_ready = 1;
    repeat (2) begin
      cyc();
      chk("post clear empty", 32'(to_rob), 0);
    end
    // illegal all-zero word
    if_valid = 1; if_pc = 32'h400; if_inst = 32'h0;
    cyc();
    if_valid = 0;
    cyc();
    chk("ill to_rob", 32'(to_rob), 1);
    chk("ill flag", 32'(d_illegal), 1);
    chk("ill to_rs", 32'(to_rs), 0);
    chk("ill to_lsb", 32'(to_lsb), 0);
    chk("ill op", 32'(d_op), 0);
    // asynchronous reset while dispatching
    if_valid = 1; if_inst = 32'hFFF10093;
    cyc();
    cyc();
    chk("pre rst to_rob", 32'(to_rob), 1);
    rst_n_in = 0;
    #1;
    chk("async rst to_rob", 32'(to_rob), 0);
    chk("async rst to_rs", 32'(to_rs), 0);
    chk("async rst d_op", 32'(d_op), 0);
    cyc();
    rst_n_in = 1; if_valid = 0;
    cyc();
    chk("post rst if_ready", 32'(if_ready), 1);
    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rdy_in = $urandom_range(9) != 0;
      clear = $urandom_range(39) == 0;
      if_valid = $urandom_range(2) != 0;
      if_pc = $urandom;
      if_inst = rand_inst();
      rob_ready = $urandom_range(4) != 0;
      rs_ready = $urandom_range(3) != 0;
      lsb_ready = $urandom_range(3) != 0;
      rob_tag = 4'($urandom);
      cyc();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
